// File: rtl/enemy_hit_detect_pkg.sv
// Shared definitions for the enemy hit detector: FSM state encoding,
// default hold length and enemy hit points, and a width helper.
package enemy_hit_detect_pkg;

    typedef enum logic [1:0] {
        SCAN   = 2'd0,
        COMMIT = 2'd1,
        HOLD   = 2'd2,
        WAIT   = 2'd3
    } state_t;

    localparam int HOLD_CYCLES_DEF = 64;
    localparam int ENEMY_HP_DEF    = 3;

    // Bits needed to hold a count from 0 to n inclusive.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/enemy_hit_detect_if.sv
// Pixel-stream and result bundle between the spawner/bullet logic and the
// enemy hit detector. The detector uses the slave modport.
interface enemy_hit_detect_if
    import enemy_hit_detect_pkg::*;
#(
    parameter int MAX_ENEMY_NUM         = 10,
    parameter int MAX_ENEMY_NUM_BIT_LEN = 4,
    parameter int SCORE_BIT_LEN         = 16
);
    logic                             en_i;
    logic                             v_sync_i;
    logic                             enemy_vali_i;
    logic [MAX_ENEMY_NUM_BIT_LEN-1:0] curr_enemy_idx_i;
    logic                             bullet_vali_i;
    logic [MAX_ENEMY_NUM-1:0]         disappear_o;
    logic                             hit_pulse_o;
    logic [SCORE_BIT_LEN-1:0]         score_o;

    modport master (
        output en_i, v_sync_i, enemy_vali_i, curr_enemy_idx_i, bullet_vali_i,
        input  disappear_o, hit_pulse_o, score_o
    );

    modport slave (
        input  en_i, v_sync_i, enemy_vali_i, curr_enemy_idx_i, bullet_vali_i,
        output disappear_o, hit_pulse_o, score_o
    );
endinterface

// File: rtl/enemy_hit_popcount.sv
// Combinational population count of the per-slot kill mask.
module enemy_hit_popcount
    import enemy_hit_detect_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int CNT_W = count_width(WIDTH)
) (
    input  logic [WIDTH-1:0] mask,
    output logic [CNT_W-1:0] count
);

    // Sum of the set bits in mask.
    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + CNT_W'(mask[i]);
        end
    end

endmodule

// File: rtl/enemy_hit_detect.sv
// Pixel-level enemy/bullet collision detector. Hits are latched per enemy
// slot over a frame, committed at the start of vertical sync, and the kill
// mask is then held on disappear_o long enough for the run-clock spawner.
// Optional macro ENEMY_HP_EN: enemies need ENEMY_HP frames with hits to die.
module enemy_hit_detect
    import enemy_hit_detect_pkg::*;
#(
    parameter int MAX_ENEMY_NUM         = 10,
    parameter int MAX_ENEMY_NUM_BIT_LEN = 4,
    parameter int HOLD_CYCLES           = HOLD_CYCLES_DEF,
    parameter int SCORE_BIT_LEN         = 16
`ifdef ENEMY_HP_EN
    ,
    parameter int ENEMY_HP              = ENEMY_HP_DEF
`endif
) (
    input logic               clk_vga,
    input logic               rst,
    enemy_hit_detect_if.slave bus
);

    localparam int POP_W = count_width(MAX_ENEMY_NUM);
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam int SUM_W = SCORE_BIT_LEN + POP_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t                           state;
    logic                             v_sync_q;
    logic                             sync_fall;
    logic [CNT_W-1:0]                 cnt;
    logic [MAX_ENEMY_NUM_BIT_LEN-1:0] idx;
    logic [MAX_ENEMY_NUM-1:0]         hit_set;
    logic [MAX_ENEMY_NUM-1:0]         hit_mask;
    logic [MAX_ENEMY_NUM-1:0]         kill_mask;
    logic [POP_W-1:0]                 kill_cnt;

    // Score plus new kills, clamped at the counter's all-ones value.
    function automatic logic [SCORE_BIT_LEN-1:0] sat_add(
        input logic [SCORE_BIT_LEN-1:0] a,
        input logic [POP_W-1:0]         b
    );
        logic [SUM_W-1:0] sum;
        logic [SUM_W-1:0] max_v;
        sum   = SUM_W'(a) + SUM_W'(b);
        max_v = SUM_W'({SCORE_BIT_LEN{1'b1}});
        return (sum > max_v) ? {SCORE_BIT_LEN{1'b1}} : sum[SCORE_BIT_LEN-1:0];
    endfunction

    assign idx       = bus.curr_enemy_idx_i;
    assign sync_fall = v_sync_q & ~bus.v_sync_i;

    // One-hot of the slot overlapped this cycle; out-of-range slots match nothing.
    always_comb begin
        hit_set = '0;
        for (int i = 0; i < MAX_ENEMY_NUM; i++) begin
            if (bus.en_i && bus.v_sync_i && bus.enemy_vali_i && bus.bullet_vali_i &&
                int'(idx) == i) begin
                hit_set[i] = 1'b1;
            end
        end
    end

    // Sticky per-frame hit mask; commit hands it off and restarts accumulation.
    always_ff @(posedge clk_vga) begin
        if (rst) begin
            hit_mask <= '0;
        end else if (state == COMMIT) begin
            hit_mask <= hit_set;
        end else begin
            hit_mask <= hit_mask | hit_set;
        end
    end

`ifdef ENEMY_HP_EN
    localparam int HP_W = $clog2(ENEMY_HP + 1);
    localparam logic [HP_W-1:0] HP_FULL = HP_W'(ENEMY_HP);

    logic [HP_W-1:0] hp [MAX_ENEMY_NUM];

    // A slot dies on the frame whose hit takes its last hit point.
    always_comb begin
        kill_mask = '0;
        for (int i = 0; i < MAX_ENEMY_NUM; i++) begin
            kill_mask[i] = hit_mask[i] && (hp[i] == HP_W'(1));
        end
    end

    // Hit points drop once per hit frame at commit and refill on a kill.
    always_ff @(posedge clk_vga) begin
        if (rst) begin
            for (int i = 0; i < MAX_ENEMY_NUM; i++) hp[i] <= HP_FULL;
        end else if (state == COMMIT) begin
            for (int i = 0; i < MAX_ENEMY_NUM; i++) begin
                if (hit_mask[i]) begin
                    hp[i] <= (hp[i] == HP_W'(1)) ? HP_FULL : hp[i] - HP_W'(1);
                end
            end
        end
    end
`else
    assign kill_mask = hit_mask;
`endif

    enemy_hit_popcount #(
        .WIDTH (MAX_ENEMY_NUM),
        .CNT_W (POP_W)
    ) u_popcount (
        .mask  (kill_mask),
        .count (kill_cnt)
    );

    // Commit FSM: one commit per sync falling edge, then a fixed-length hold.
    always_ff @(posedge clk_vga) begin
        if (rst) begin
            state           <= SCAN;
            v_sync_q        <= 1'b0;
            cnt             <= '0;
            bus.disappear_o <= '0;
            bus.hit_pulse_o <= 1'b0;
            bus.score_o     <= '0;
        end else begin
            v_sync_q        <= bus.v_sync_i;
            bus.hit_pulse_o <= 1'b0;
            case (state)
                SCAN: begin
                    if (sync_fall) state <= COMMIT;
                end
                COMMIT: begin
                    bus.disappear_o <= kill_mask;
                    bus.score_o     <= sat_add(bus.score_o, kill_cnt);
                    bus.hit_pulse_o <= |kill_mask;
                    cnt             <= '0;
                    state           <= HOLD;
                end
                HOLD: begin
                    if (cnt == CNT_LAST) begin
                        bus.disappear_o <= '0;
                        state           <= WAIT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (bus.v_sync_i) state <= SCAN;
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_enemy_hit_detect.sv
// Self-checking bench for enemy_hit_detect. A second instance with a 2-bit
// score shares the same input stream to exercise saturation.
module tb_enemy_hit_detect;

    localparam int NE   = 10;
    localparam int HOLD = 64;
`ifdef ENEMY_HP_EN
    localparam int HP = 3;
`else
    localparam int HP = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    enemy_hit_detect_if #(.MAX_ENEMY_NUM(NE), .MAX_ENEMY_NUM_BIT_LEN(4), .SCORE_BIT_LEN(16)) b1 ();
    enemy_hit_detect_if #(.MAX_ENEMY_NUM(NE), .MAX_ENEMY_NUM_BIT_LEN(4), .SCORE_BIT_LEN(2))  b2 ();

    assign b2.en_i             = b1.en_i;
    assign b2.v_sync_i         = b1.v_sync_i;
    assign b2.enemy_vali_i     = b1.enemy_vali_i;
    assign b2.curr_enemy_idx_i = b1.curr_enemy_idx_i;
    assign b2.bullet_vali_i    = b1.bullet_vali_i;

    enemy_hit_detect #(.MAX_ENEMY_NUM(NE), .MAX_ENEMY_NUM_BIT_LEN(4), .HOLD_CYCLES(HOLD),
                       .SCORE_BIT_LEN(16)) dut (.clk_vga(clk), .rst(rst), .bus(b1));
    enemy_hit_detect #(.MAX_ENEMY_NUM(NE), .MAX_ENEMY_NUM_BIT_LEN(4), .HOLD_CYCLES(HOLD),
                       .SCORE_BIT_LEN(2))  dut2 (.clk_vga(clk), .rst(rst), .bus(b2));

    int total = 0;
    int bad   = 0;

    // Reference model: slots hit in the current frame, hit points, scores.
    bit frame_hit [NE];
    int hp_m      [NE];
    int score_m;
    int score2_m;

    task automatic model_reset();
        for (int i = 0; i < NE; i++) begin
            frame_hit[i] = 1'b0;
            hp_m[i]      = HP;
        end
        score_m  = 0;
        score2_m = 0;
    endtask

    // Close the frame: which slots die, and the new saturated scores.
    task automatic model_commit(output logic [NE-1:0] kill);
        int n;
        kill = '0;
        n = 0;
        for (int i = 0; i < NE; i++) begin
            if (frame_hit[i]) begin
                hp_m[i] = hp_m[i] - 1;
                if (hp_m[i] == 0) begin
                    kill[i] = 1'b1;
                    hp_m[i] = HP;
                    n++;
                end
            end
            frame_hit[i] = 1'b0;
        end
        score_m  = (score_m + n > 65535) ? 65535 : score_m + n;
        score2_m = (score2_m + n > 3) ? 3 : score2_m + n;
    endtask

    // One clock; the model records what the DUT sees at this edge.
    task automatic tick();
        @(posedge clk);
        if (!rst && b1.v_sync_i && b1.en_i && b1.enemy_vali_i && b1.bullet_vali_i &&
            b1.curr_enemy_idx_i < 4'(NE)) begin
            frame_hit[b1.curr_enemy_idx_i] = 1'b1;
        end
        #1;
    endtask

    task automatic drive_hit(input int idx, input int n);
        b1.en_i = 1'b1;
        b1.v_sync_i = 1'b1;
        b1.enemy_vali_i = 1'b1;
        b1.bullet_vali_i = 1'b1;
        b1.curr_enemy_idx_i = 4'(idx);
        repeat (n) tick();
        b1.enemy_vali_i = 1'b0;
        b1.bullet_vali_i = 1'b0;
    endtask

    // Drop sync and watch the whole commit/hold window cycle by cycle.
    // restart_at / glitch_at: hold cycle at which sync rises / falls again (-1 = never).
    task automatic commit(input int restart_at, input int glitch_at, input bit new_hits);
        logic [NE-1:0] exp_kill, exp_d;
        logic exp_p;
        model_commit(exp_kill);
        b1.v_sync_i = 1'b0;
        b1.enemy_vali_i = 1'b0;
        b1.bullet_vali_i = 1'b0;
        for (int k = 1; k <= HOLD + 6; k++) begin
            if (restart_at >= 0 && k == restart_at + 2) b1.v_sync_i = 1'b1;
            if (new_hits && restart_at >= 0 && k >= restart_at + 2 && k < restart_at + 7) begin
                b1.en_i = 1'b1;
                b1.enemy_vali_i = 1'b1;
                b1.bullet_vali_i = 1'b1;
                b1.curr_enemy_idx_i = 4'd5;
            end else begin
                b1.enemy_vali_i = 1'b0;
                b1.bullet_vali_i = 1'b0;
            end
            if (glitch_at >= 0 && k == glitch_at + 2) b1.v_sync_i = 1'b0;
            tick();
            exp_d = (k >= 2 && k <= HOLD + 1) ? exp_kill : '0;
            exp_p = (k == 2) && (exp_kill != '0);
            total++;
            if (b1.disappear_o !== exp_d)
                $display("FAIL disappear k=%0d: got %b want %b", k, b1.disappear_o, exp_d);
            if (b1.disappear_o !== exp_d) bad++;
            total++;
            if (b1.hit_pulse_o !== exp_p) begin
                $display("FAIL hit_pulse k=%0d: got %b want %b", k, b1.hit_pulse_o, exp_p);
                bad++;
            end
            if (k == 2) begin
                total++;
                if (b1.score_o !== 16'(score_m)) begin
                    $display("FAIL score: got %0d want %0d", b1.score_o, score_m);
                    bad++;
                end
                total++;
                if (b2.score_o !== 2'(score2_m)) begin
                    $display("FAIL score_sat: got %0d want %0d", b2.score_o, score2_m);
                    bad++;
                end
            end
        end
        b1.v_sync_i = 1'b1;
        b1.enemy_vali_i = 1'b0;
        b1.bullet_vali_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic run_frame(input int n);
        b1.v_sync_i = 1'b1;
        for (int c = 0; c < n; c++) begin
            b1.en_i = ($urandom_range(0, 7) != 0);
            b1.enemy_vali_i = $urandom_range(0, 1) != 0;
            b1.bullet_vali_i = ($urandom_range(0, 2) == 0);
            b1.curr_enemy_idx_i = 4'($urandom_range(0, 15));
            tick();
        end
        b1.en_i = 1'b1;
        b1.enemy_vali_i = 1'b0;
        b1.bullet_vali_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total += 4;
        if (b1.disappear_o !== '0) begin $display("FAIL reset_disappear: got %b want 0", b1.disappear_o); bad++; end
        if (b1.score_o !== '0) begin $display("FAIL reset_score: got %0d want 0", b1.score_o); bad++; end
        if (b1.hit_pulse_o !== 1'b0) begin $display("FAIL reset_pulse: got %b want 0", b1.hit_pulse_o); bad++; end
        if (b2.score_o !== '0) begin $display("FAIL reset_score2: got %0d want 0", b2.score_o); bad++; end
        rst = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic test_single_hit();
        drive_hit(3, 5);
        tick();
        commit(-1, -1, 1'b0);
    endtask

    task automatic test_no_bullet();
        b1.en_i = 1'b1;
        b1.v_sync_i = 1'b1;
        b1.enemy_vali_i = 1'b1;
        b1.bullet_vali_i = 1'b0;
        for (int c = 0; c < 20; c++) begin
            b1.curr_enemy_idx_i = 4'($urandom_range(0, 9));
            tick();
        end
        b1.enemy_vali_i = 1'b0;
        commit(-1, -1, 1'b0);
    endtask

    task automatic test_multi_range();
        drive_hit(0, 3);
        drive_hit(12, 3);
        drive_hit(9, 3);
        tick();
        commit(-1, -1, 1'b0);
    endtask

    task automatic test_early_restart();
        drive_hit(7, 2);
        tick();
        commit(10, -1, 1'b1);
        tick();
        commit(-1, -1, 1'b0);
    endtask

    task automatic test_sync_in_hold();
        drive_hit(4, 2);
        tick();
        commit(10, 20, 1'b0);
        commit(-1, -1, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            run_frame(int'($urandom_range(10, 40)));
            commit(-1, -1, 1'b0);
        end
    endtask

    task automatic test_saturation();
        for (int f = 0; f < 3; f++) begin
            for (int s = 0; s < NE; s++) drive_hit(s, 1);
            tick();
            commit(-1, -1, 1'b0);
        end
        total++;
        if (b2.score_o !== 2'd3) begin
            $display("FAIL sat_final: got %0d want 3", b2.score_o);
            bad++;
        end
    endtask

    task automatic test_hp();
        test_reset();
        for (int f = 0; f < 3; f++) begin
            drive_hit(2, 4);
            tick();
            commit(-1, -1, 1'b0);
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [NE-1:0] kill;
        drive_hit(1, 2);
        drive_hit(6, 2);
        tick();
        model_commit(kill);
        b1.v_sync_i = 1'b0;
        repeat (2) tick();
        total++;
        if (b1.disappear_o !== kill) begin
            $display("FAIL midhold_pre: got %b want %b", b1.disappear_o, kill);
            bad++;
        end
        repeat (5) tick();
        rst = 1'b1;
        tick();
        total += 3;
        if (b1.disappear_o !== '0) begin $display("FAIL midhold_disappear: got %b want 0", b1.disappear_o); bad++; end
        if (b1.score_o !== '0) begin $display("FAIL midhold_score: got %0d want 0", b1.score_o); bad++; end
        if (b1.hit_pulse_o !== 1'b0) begin $display("FAIL midhold_pulse: got %b want 0", b1.hit_pulse_o); bad++; end
        rst = 1'b0;
        b1.v_sync_i = 1'b1;
        model_reset();
        tick();
        drive_hit(8, 1);
        tick();
        commit(-1, -1, 1'b0);
    endtask

    initial begin
        b1.en_i = 1'b1;
        b1.v_sync_i = 1'b1;
        b1.enemy_vali_i = 1'b0;
        b1.bullet_vali_i = 1'b0;
        b1.curr_enemy_idx_i = '0;
        model_reset();
        test_reset();
        test_single_hit();
        test_no_bullet();
        test_multi_range();
        test_early_restart();
        test_sync_in_hold();
        test_random();
        test_saturation();
        test_hp();
        test_reset_mid_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
